switch_debouncer: RTL
=====================

Name: switch_debouncer

Overview:
Conditions the raw slide-switch inputs before they reach the LED/counter logic. Each channel is synchronised into the board_clk domain and debounced with a per-channel stability counter. The block outputs clean levels plus one-cycle rise/fall strobes that downstream logic uses as enables. It sits directly between the board switch pins and the LED driver stage.

Parameters:
N_CH, 4, number of switch channels.
DEBOUNCE_CYCLES, 50000, consecutive board_clk cycles of a stable new level required to accept it; legal range 2 .. 2^CNT_W.
CNT_W, 16, width of each per-channel stability counter.

Ports:
board_clk  input  1  system clock; all state updates on rising edge.
rst_n  input  1  asynchronous, active-low reset; assertion takes effect immediately, release is sampled on board_clk.
switches  input  N_CH  raw, asynchronous, bouncy switch levels.
switches_db  output  N_CH  debounced switch levels.
sw_rise  output  N_CH  one-cycle strobe per channel on an accepted 0->1 transition.
sw_fall  output  N_CH  one-cycle strobe per channel on an accepted 1->0 transition.

Behaviour:
- Reset (rst_n=0): sync FFs, counters, switches_db, sw_rise and sw_fall all go to 0, asynchronously.
- Synchroniser: two-flop chain per channel (sync1 <= switches, sync2 <= sync1); only sync2 feeds the debounce logic.
- Per channel, each clock:
  - sync2 == switches_db: counter <= 0; no strobe.
  - sync2 != switches_db and counter < DEBOUNCE_CYCLES-1: counter <= counter+1; no strobe.
  - sync2 != switches_db and counter == DEBOUNCE_CYCLES-1: switches_db <= sync2; counter <= 0; sw_rise (if sync2=1) or sw_fall (if sync2=0) is high for exactly the next cycle.
- Each channel is an implicit two-state FSM: STABLE (counter=0, match) and PENDING (mismatch, counting). A single matching cycle returns the channel to STABLE and clears the counter, so a glitch never partially accumulates.
- Latency: a clean pin step is reflected on switches_db exactly 2 + DEBOUNCE_CYCLES rising edges after the first edge that samples it. The strobe is coincident with the switches_db change.
- Strobes are registered outputs and are never high for more than 1 cycle per accepted transition. sw_rise and sw_fall are never high together on the same channel.
- Channels are fully independent. Simultaneous transitions on several channels produce simultaneous strobes.
- Counter width: the counter never exceeds DEBOUNCE_CYCLES-1 and never wraps. Arithmetic is unsigned CNT_W-bit.
- Switch held high through reset: after release, switches_db rises after 2 + DEBOUNCE_CYCLES cycles with one sw_rise pulse. This is intentional.
- Reset mid-debounce discards the pending count. No strobe is emitted.
- No combinational path exists from switches to any output.

Test Plan (DEBOUNCE_CYCLES=4, N_CH=4 unless stated):
1. Reset with switches=4'b0000, release, hold 20 cycles -> switches_db=0, no strobes, counters 0.
2. Clean step switches[0] 0->1 at edge E -> switches_db[0]=1 and sw_rise[0]=1 in the cycle after edge E+5, sw_rise[0]=0 one cycle later. Then step 1->0 -> sw_fall[0] with the same timing.
3. Bounce on switches[1]: 1 for 3 cycles, 0 for 1, 1 for 3, 0 for 2, then 1 steady -> switches_db[1] changes only after 4 consecutive synchronised highs following the last low. Exactly one sw_rise[1].
4. switches 4'b0000 -> 4'b1010 in the same cycle -> switches_db=4'b1010, sw_rise=4'b1010 asserted in the same cycle, sw_fall=0.
5. switches[2] high, then rst_n pulsed low after 3 mismatch cycles -> outputs 0 immediately (async). After release, the full 2+4 cycle latency restarts and a single sw_rise[2] is produced.
6. DEBOUNCE_CYCLES=50000, CNT_W=16: hold a step for 49999 synchronised cycles then drop -> no change. Hold for 50000 -> accepted. Counter never exceeds 49999.

Source files
------------

// File: rtl/switch_debouncer.sv
// switch_debouncer: synchronises raw slide-switch pins into board_clk and
// debounces each channel with its own stability counter. Produces clean
// levels plus one-cycle rise/fall strobes for the LED/counter stage.
module switch_debouncer #(
  parameter int unsigned N_CH            = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned CNT_W           = 16
) (
  input  logic            board_clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] switches,
  output logic [N_CH-1:0] switches_db,
  output logic [N_CH-1:0] sw_rise,
  output logic [N_CH-1:0] sw_fall
);

  // Terminal count: the mismatch cycle on which a new level is accepted.
  localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    ST_STABLE  = 1'b0,
    ST_PENDING = 1'b1
  } ch_state_e;

  logic [N_CH-1:0] r_sync1;
  logic [N_CH-1:0] r_sync2;

  // Two-flop synchroniser per channel; only r_sync2 is used downstream.
  always_ff @(posedge board_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= switches;
      r_sync2 <= r_sync1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < int'(N_CH); gi++) begin : g_ch
      ch_state_e        r_state;
      logic [CNT_W-1:0] r_cnt;
      logic             r_db;
      logic             r_rise;
      logic             r_fall;
      logic             w_mismatch;
      logic             w_last;

      assign w_mismatch = r_sync2[gi] ^ r_db;
      assign w_last     = (r_cnt == LP_CNT_LAST);

      // Per-channel STABLE/PENDING machine; any matching cycle clears the count.
      always_ff @(posedge board_clk or negedge rst_n) begin
        if (!rst_n) begin
          r_state <= ST_STABLE;
          r_cnt   <= '0;
          r_db    <= 1'b0;
          r_rise  <= 1'b0;
          r_fall  <= 1'b0;
        end else begin
          r_rise <= 1'b0;
          r_fall <= 1'b0;
          case (r_state)
            ST_STABLE: begin
              if (w_mismatch) begin
                r_cnt   <= CNT_W'(1);
                r_state <= ST_PENDING;
              end else begin
                r_cnt <= '0;
              end
            end
            ST_PENDING: begin
              if (!w_mismatch) begin
                r_cnt   <= '0;
                r_state <= ST_STABLE;
              end else if (w_last) begin
                r_db    <= r_sync2[gi];
                r_rise  <= r_sync2[gi];
                r_fall  <= ~r_sync2[gi];
                r_cnt   <= '0;
                r_state <= ST_STABLE;
              end else begin
                r_cnt <= r_cnt + CNT_W'(1);
              end
            end
            default: begin
              r_cnt   <= '0;
              r_state <= ST_STABLE;
            end
          endcase
        end
      end

      assign switches_db[gi] = r_db;
      assign sw_rise[gi]     = r_rise;
      assign sw_fall[gi]     = r_fall;
    end
  endgenerate

endmodule
